// File: rtl/debounce_pkg.sv
// Shared constants and helpers for the multi-channel debouncer and its bench.
package debounce_pkg;

    localparam int unsigned DEBOUNCE_SYNC_STAGES = 2;
    localparam int unsigned DEBOUNCE_CNT_WIDTH   = 16;

    // Width of the shared prescaler counter; at least one bit so the type stays legal.
    function automatic int unsigned pre_width(input int unsigned prescale);
        return (prescale <= 1) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, stability counter, committed level and strobes.
module debounce_chan
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEBOUNCE_SYNC_STAGES,
    parameter int unsigned CNT_WIDTH   = DEBOUNCE_CNT_WIDTH,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 din_i,
    input  logic                 tick_i,
    input  logic [CNT_WIDTH-1:0] teff_i,
    output logic                 dout_o,
    output logic                 rise_o,
    output logic                 fall_o,
    output logic                 busy_o
);

    localparam logic [CNT_WIDTH:0] IncOne = (CNT_WIDTH+1)'(1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   dout_q, dout_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   s;
    logic [CNT_WIDTH:0]     cnt_inc;

    // Next-state: shift the synchroniser, count stable ticks, commit on reaching teff.
    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], din_i};
        s       = sync_q[SYNC_STAGES-1];
        // One bit wider so the compare never sees a wrapped value.
        cnt_inc = {1'b0, cnt_q} + IncOne;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s == dout_q) begin
            // Input agrees with committed level: any pending candidate is a glitch.
            cnt_d = '0;
        end else if (tick_i) begin
            // >= so that lowering teff mid-count commits on the very next tick.
            if (cnt_inc >= {1'b0, teff_i}) begin
                dout_d = s;
                cnt_d  = '0;
                rise_d = s;
                fall_d = ~s;
            end else begin
                cnt_d = cnt_inc[CNT_WIDTH-1:0];
            end
        end
    end

    // State register with synchronous reset; reset discards any pending count silently.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            cnt_q  <= '0;
            dout_q <= RESET_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign dout_o = dout_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
    assign busy_o = |cnt_q;

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel debouncer top: shared prescaler, threshold clamp and channel array.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned SYNC_STAGES = DEBOUNCE_SYNC_STAGES,
    parameter int unsigned CNT_WIDTH   = DEBOUNCE_CNT_WIDTH,
    parameter int unsigned PRESCALE    = 1,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CHANNELS-1:0]  din,
    input  logic [CNT_WIDTH-1:0] thresh,
    output logic [CHANNELS-1:0]  dout,
    output logic [CHANNELS-1:0]  rise,
    output logic [CHANNELS-1:0]  fall,
    output logic [CHANNELS-1:0]  busy
);

    localparam int unsigned PreW = pre_width(PRESCALE);

    logic                 tick;
    logic [CNT_WIDTH-1:0] teff;

    // A threshold of zero behaves as one tick.
    always_comb begin
        teff = thresh;
        if (thresh == '0) begin
            teff = CNT_WIDTH'(1);
        end
    end

    if (PRESCALE > 1) begin : g_pre
        localparam logic [PreW-1:0] PreMax = PreW'(PRESCALE - 1);

        logic [PreW-1:0] pre_q, pre_d;

        // Free-running tick divider, wraps at PRESCALE-1.
        always_comb begin
            pre_d = pre_q + PreW'(1);
            if (pre_q == PreMax) begin
                pre_d = '0;
            end
        end

        // Prescaler register.
        always_ff @(posedge clk) begin
            if (rst) begin
                pre_q <= '0;
            end else begin
                pre_q <= pre_d;
            end
        end

        assign tick = (pre_q == PreMax);
    end else begin : g_no_pre
        assign tick = 1'b1;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        debounce_chan #(
            .SYNC_STAGES(SYNC_STAGES),
            .CNT_WIDTH  (CNT_WIDTH),
            .RESET_VAL  (RESET_VAL)
        ) u_chan (
            .clk_i (clk),
            .rst_i (rst),
            .din_i (din[i]),
            .tick_i(tick),
            .teff_i(teff),
            .dout_o(dout[i]),
            .rise_o(rise[i]),
            .fall_o(fall[i]),
            .busy_o(busy[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed self-checking bench for debounce_multi (PRESCALE=1 and PRESCALE=4 instances).
module tb_debounce_multi;
    import debounce_pkg::*;

    localparam int unsigned CH = 3;
    localparam int unsigned CW = DEBOUNCE_CNT_WIDTH;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] din_a, dout_a, rise_a, fall_a, busy_a;
    logic [CH-1:0] din_p, dout_p, rise_p, fall_p, busy_p;
    logic [CW-1:0] thresh_a, thresh_p;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    debounce_multi #(
        .CHANNELS   (CH),
        .SYNC_STAGES(DEBOUNCE_SYNC_STAGES),
        .CNT_WIDTH  (CW),
        .PRESCALE   (1),
        .RESET_VAL  (1'b0)
    ) dut_a (
        .clk   (clk),
        .rst   (rst),
        .din   (din_a),
        .thresh(thresh_a),
        .dout  (dout_a),
        .rise  (rise_a),
        .fall  (fall_a),
        .busy  (busy_a)
    );

    debounce_multi #(
        .CHANNELS   (CH),
        .SYNC_STAGES(DEBOUNCE_SYNC_STAGES),
        .CNT_WIDTH  (CW),
        .PRESCALE   (4),
        .RESET_VAL  (1'b0)
    ) dut_p (
        .clk   (clk),
        .rst   (rst),
        .din   (din_p),
        .thresh(thresh_p),
        .dout  (dout_p),
        .rise  (rise_p),
        .fall  (fall_p),
        .busy  (busy_p)
    );

    // Advance one posedge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; din_a = 3'b101; thresh_a = CW'(3); din_p = 3'b000; thresh_p = CW'(2);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({dout_a, rise_a, fall_a, busy_a} !== 12'b0) begin
                errors++;
                $display("FAIL reset_hold: got %b required 0", {dout_a, rise_a, fall_a, busy_a});
            end
        end
        rst = 1'b0;
        for (int k = 0; k <= 4; k++) begin
            step();
            if (k == 0) begin
                checks++;
                if ({dout_a, rise_a, fall_a, busy_a, dout_p} !== 15'b0) begin
                    errors++;
                    $display("FAIL reset_first_cycle: got %b required 0",
                             {dout_a, rise_a, fall_a, busy_a, dout_p});
                end
            end
            if (k == 3) begin
                checks++;
                if (dout_a !== 3'b000 || busy_a !== 3'b101) begin
                    errors++;
                    $display("FAIL reset_pre_commit: dout=%b busy=%b required 000/101",
                             dout_a, busy_a);
                end
            end
            if (k == 4) begin
                checks++;
                if (dout_a !== 3'b101 || rise_a !== 3'b101 || busy_a !== 3'b000) begin
                    errors++;
                    $display("FAIL reset_commit: dout=%b rise=%b busy=%b required 101/101/000",
                             dout_a, rise_a, busy_a);
                end
            end
        end
    endtask

    task automatic test_step();
        din_a = 3'b000; thresh_a = CW'(3);
        repeat (12) step();
        checks++;
        if (dout_a !== 3'b000) begin
            errors++;
            $display("FAIL step_settle: dout=%b required 000", dout_a);
        end
        din_a[0] = 1'b1;
        for (int k = 0; k <= 5; k++) begin
            step();
            if (k == 3) begin
                checks++;
                if (dout_a !== 3'b000 || rise_a !== 3'b000) begin
                    errors++;
                    $display("FAIL step_early: dout=%b rise=%b required 000/000", dout_a, rise_a);
                end
            end
            if (k == 4) begin
                checks++;
                if (dout_a !== 3'b001 || rise_a !== 3'b001 || fall_a !== 3'b000) begin
                    errors++;
                    $display("FAIL step_commit: dout=%b rise=%b fall=%b required 001/001/000",
                             dout_a, rise_a, fall_a);
                end
            end
            if (k == 5) begin
                checks++;
                if (dout_a !== 3'b001 || rise_a !== 3'b000) begin
                    errors++;
                    $display("FAIL step_strobe_end: dout=%b rise=%b required 001/000",
                             dout_a, rise_a);
                end
            end
        end
    endtask

    task automatic test_toggle();
        int nrise;
        thresh_a = CW'(4);
        for (int i = 0; i < 8; i++) begin
            din_a[1] = ~din_a[1];
            step();
            checks++;
            if (dout_a !== 3'b001 || rise_a !== 3'b000 || fall_a !== 3'b000) begin
                errors++;
                $display("FAIL toggle_quiet: dout=%b rise=%b fall=%b required 001/000/000",
                         dout_a, rise_a, fall_a);
            end
        end
        nrise = 0;
        din_a[1] = 1'b1;
        for (int k = 0; k <= 9; k++) begin
            step();
            if (rise_a[1]) nrise++;
            if (k == 4) begin
                checks++;
                if (dout_a[1] !== 1'b0) begin
                    errors++;
                    $display("FAIL toggle_early: dout1=%b required 0", dout_a[1]);
                end
            end
            if (k == 5) begin
                checks++;
                if (dout_a[1] !== 1'b1 || rise_a[1] !== 1'b1) begin
                    errors++;
                    $display("FAIL toggle_commit: dout1=%b rise1=%b required 1/1",
                             dout_a[1], rise_a[1]);
                end
            end
        end
        checks++;
        if (nrise != 1 || dout_a !== 3'b011) begin
            errors++;
            $display("FAIL toggle_rise_count: rises=%0d dout=%b required 1/011", nrise, dout_a);
        end
    endtask

    task automatic test_prescale();
        int found;
        int nstrobe;
        din_p = 3'b100; thresh_p = CW'(2);
        repeat (30) step();
        checks++;
        if (dout_p !== 3'b100) begin
            errors++;
            $display("FAIL pre_settle: dout=%b required 100", dout_p);
        end
        found = -1;
        din_p[2] = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (fall_p[2] && found < 0) found = k;
        end
        checks++;
        if (found < 6 || found > 10 || dout_p !== 3'b000) begin
            errors++;
            $display("FAIL pre_fall_window: edge=%0d dout=%b required 6..10/000", found, dout_p);
        end
        nstrobe = 0;
        din_p[2] = 1'b1;
        for (int k = 0; k < 23; k++) begin
            if (k == 3) din_p[2] = 1'b0;
            step();
            if (rise_p != 3'b000 || fall_p != 3'b000) nstrobe++;
        end
        checks++;
        if (nstrobe != 0 || dout_p !== 3'b000) begin
            errors++;
            $display("FAIL pre_glitch: strobes=%0d dout=%b required 0/000", nstrobe, dout_p);
        end
    endtask

    task automatic test_thresh_change();
        thresh_a = CW'(10);
        din_a[0] = 1'b0;
        for (int k = 0; k <= 7; k++) begin
            step();
            if (k == 6) begin
                checks++;
                if (busy_a[0] !== 1'b1 || dout_a !== 3'b011) begin
                    errors++;
                    $display("FAIL thr_midcount: busy0=%b dout=%b required 1/011",
                             busy_a[0], dout_a);
                end
                thresh_a = CW'(3);
            end
            if (k == 7) begin
                checks++;
                if (dout_a !== 3'b010 || fall_a !== 3'b001) begin
                    errors++;
                    $display("FAIL thr_lowered: dout=%b fall=%b required 010/001",
                             dout_a, fall_a);
                end
            end
        end
        thresh_a = CW'(10);
        din_a[0] = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            step();
        end
        checks++;
        if (busy_a[0] !== 1'b1 || dout_a !== 3'b010) begin
            errors++;
            $display("FAIL thr_rst_pre: busy0=%b dout=%b required 1/010", busy_a[0], dout_a);
        end
        rst = 1'b1;
        step();
        checks++;
        if ({dout_a, busy_a, rise_a, fall_a} !== 12'b0) begin
            errors++;
            $display("FAIL thr_rst_midcount: got %b required 0", {dout_a, busy_a, rise_a, fall_a});
        end
        rst = 1'b0;
        step();
        checks++;
        if ({dout_a, rise_a, fall_a} !== 9'b0) begin
            errors++;
            $display("FAIL thr_rst_after: got %b required 0", {dout_a, rise_a, fall_a});
        end
    endtask

    task automatic test_thresh_zero();
        din_a = 3'b000; thresh_a = CW'(3);
        repeat (8) step();
        checks++;
        if (dout_a !== 3'b000) begin
            errors++;
            $display("FAIL zero_settle: dout=%b required 000", dout_a);
        end
        thresh_a = '0;
        din_a[0] = 1'b1;
        for (int k = 0; k <= 3; k++) begin
            step();
            if (k == 1) begin
                checks++;
                if (dout_a !== 3'b000) begin
                    errors++;
                    $display("FAIL zero_early: dout=%b required 000", dout_a);
                end
            end
            if (k == 2) begin
                checks++;
                if (dout_a !== 3'b001 || rise_a !== 3'b001) begin
                    errors++;
                    $display("FAIL zero_commit: dout=%b rise=%b required 001/001", dout_a, rise_a);
                end
            end
            if (k == 3) begin
                checks++;
                if (rise_a !== 3'b000 || dout_a !== 3'b001) begin
                    errors++;
                    $display("FAIL zero_strobe_end: dout=%b rise=%b required 001/000",
                             dout_a, rise_a);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_step();
        test_toggle();
        test_prescale();
        test_thresh_change();
        test_thresh_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
